// File: rtl/karat_pkg.sv
// Shared helpers for the pipelined Karatsuba multiplier: latency function
// and the sideband record carried alongside each operand pair.
package karat_pkg;

  localparam int KMP_WTAG = 4;

  typedef struct packed {
    logic                neg;
    logic [KMP_WTAG-1:0] tag;
  } kmp_side_t;

  function automatic int karat_lat(input int nlevel);
    return nlevel + 2;
  endfunction

endpackage

// File: rtl/karat_mult_pipe_lvl.sv
// One Karatsuba recursion level: unsigned wI x wI product, registered under
// i_en, total latency nLEVEL cycles (one register per level).
module karat_mult_pipe_lvl #(
  parameter int wI     = 16,
  parameter int nLEVEL = 2
) (
  input  logic            clk,
  input  logic            i_en,
  input  logic [wI-1:0]   x,
  input  logic [wI-1:0]   y,
  output logic [2*wI-1:0] p
);

  localparam int H  = wI / 2;
  localparam int WE = 2 * wI;

  logic [H-1:0]  xh, xl, yh, yl;
  logic [H:0]    r, s;
  logic [WE-1:0] pe, qe, te, mid, sum;

  assign {xh, xl} = x;
  assign {yh, yl} = y;
  assign r = {1'b0, xh} + {1'b0, xl};
  assign s = {1'b0, yh} + {1'b0, yl};

  generate
    if (nLEVEL == 1) begin : g_leaf
      assign pe = WE'(xh) * WE'(yh);
      assign qe = WE'(xl) * WE'(yl);
      assign te = WE'(r) * WE'(s);
    end else begin : g_rec
      localparam int DW = 2 * H + 2;
      logic [2*H-1:0] pp, qq, ts;
      logic [DW-1:0]  dly_in;
      logic [nLEVEL-2:0][DW-1:0] dly;
      logic           rh, sh;
      logic [H-1:0]   rl, sl;

      karat_mult_pipe_lvl #(.wI(H), .nLEVEL(nLEVEL-1)) u_p (
        .clk(clk), .i_en(i_en), .x(xh), .y(yh), .p(pp));
      karat_mult_pipe_lvl #(.wI(H), .nLEVEL(nLEVEL-1)) u_q (
        .clk(clk), .i_en(i_en), .x(xl), .y(yl), .p(qq));
      karat_mult_pipe_lvl #(.wI(H), .nLEVEL(nLEVEL-1)) u_t (
        .clk(clk), .i_en(i_en), .x(r[H-1:0]), .y(s[H-1:0]), .p(ts));

      // carry bits and low halves of r/s wait for the t_s sub-product
      assign dly_in = {r[H], s[H], r[H-1:0], s[H-1:0]};
      always_ff @(posedge clk)
        if (i_en) begin
          dly[0] <= dly_in;
          for (int k = 1; k < nLEVEL - 1; k++) dly[k] <= dly[k-1];
        end
      assign {rh, sh, rl, sl} = dly[nLEVEL-2];

      assign pe = WE'(pp);
      assign qe = WE'(qq);
      assign te = WE'(ts) + (WE'(rh & sh) << wI)
                + (WE'({H{rh}} & sl) << H) + (WE'({H{sh}} & rl) << H);
    end
  endgenerate

  // every term fits in 2*wI bits, so modular sums are exact
  assign mid = te - pe - qe;
  assign sum = (pe << wI) + (mid << H) + qe;

  always_ff @(posedge clk)
    if (i_en) p <= sum;

endmodule

// File: rtl/karat_mult_pipe.sv
// Streaming Karatsuba multiplier: abs stage, nLEVEL recursion stages, sign
// fix stage; one global stall driven by the output handshake.
module karat_mult_pipe
  import karat_pkg::*;
#(
  parameter int wI     = 1024,
  parameter int nLEVEL = 2,
  parameter int wTAG   = 4,
  parameter int wO     = 2 * wI
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [wI-1:0]   iX,
  input  logic [wI-1:0]   iY,
  input  logic            i_signed,
  input  logic [wTAG-1:0] i_tag,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [wO-1:0]   oO,
  output logic [wTAG-1:0] o_tag,
  output logic            o_idle
);

  localparam int LAT    = karat_lat(nLEVEL);
  localparam int STAGES = LAT - 1;

  typedef struct packed {
    logic            neg;
    logic [wTAG-1:0] tag;
  } side_t;

  generate
    if (wI % (1 << nLEVEL) != 0) begin : g_bad_width
      $error("karat_mult_pipe: wI must be a multiple of 2**nLEVEL");
    end
  endgenerate

  logic                      adv;
  logic [STAGES:0]           vld_pipe;
  logic [wI-1:0]             mag_x, mag_y, abs_x, abs_y;
  side_t [STAGES-1:0]        side_pipe;
  logic [wO-1:0]             prod;

  assign adv     = !o_valid || i_ready;
  assign o_ready = adv;
  assign o_valid = vld_pipe[STAGES];
  assign o_idle  = ~|vld_pipe;

  // the most negative value maps to 2^(wI-1), still fits unsigned
  assign mag_x = (i_signed && iX[wI-1]) ? -iX : iX;
  assign mag_y = (i_signed && iY[wI-1]) ? -iY : iY;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)   vld_pipe <= '0;
    else if (adv) vld_pipe <= {vld_pipe[STAGES-1:0], i_valid};

  always_ff @(posedge clk)
    if (adv) begin
      abs_x        <= mag_x;
      abs_y        <= mag_y;
      side_pipe[0] <= '{neg: i_signed & (iX[wI-1] ^ iY[wI-1]), tag: i_tag};
      for (int k = 1; k < STAGES; k++) side_pipe[k] <= side_pipe[k-1];
    end

  karat_mult_pipe_lvl #(.wI(wI), .nLEVEL(nLEVEL)) u_lvl (
    .clk (clk),
    .i_en(adv),
    .x   (abs_x),
    .y   (abs_y),
    .p   (prod)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      oO    <= '0;
      o_tag <= '0;
    end else if (adv) begin
      oO    <= side_pipe[STAGES-1].neg ? -prod : prod;
      o_tag <= side_pipe[STAGES-1].tag;
    end

endmodule

// File: tb/tb_karat_mult_pipe.sv
// Directed and streamed checks of karat_mult_pipe (wI=16, nLEVEL=2) against a
// reference multiply scoreboard.
module tb_karat_mult_pipe;

  localparam int WI = 16;
  localparam int NL = 2;
  localparam int WT = 4;
  localparam int WO = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_signed = 1'b0;
  logic          i_ready = 1'b1;
  logic [WI-1:0] iX = '0, iY = '0;
  logic [WT-1:0] i_tag = '0;
  logic          o_ready, o_valid, o_idle;
  logic [WO-1:0] oO;
  logic [WT-1:0] o_tag;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [WO-1:0] o;
    logic [WT-1:0] tag;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  karat_mult_pipe #(.wI(WI), .nLEVEL(NL), .wTAG(WT)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .iX(iX), .iY(iY), .i_signed(i_signed), .i_tag(i_tag),
    .o_valid(o_valid), .i_ready(i_ready), .oO(oO), .o_tag(o_tag),
    .o_idle(o_idle)
  );

  function automatic logic [WO-1:0] ref_mul(input logic [WI-1:0] x, input logic [WI-1:0] y,
                                            input logic sg);
    logic signed [WO-1:0] sx, sy;
    if (sg) begin
      sx = {{WI{x[WI-1]}}, x};
      sy = {{WI{y[WI-1]}}, y};
      return sx * sy;
    end
    return {{WI{1'b0}}, x} * {{WI{1'b0}}, y};
  endfunction

  task automatic check(input string name, input logic [WO-1:0] obs, input logic [WO-1:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // scoreboard: handshakes observed mid-cycle, taking effect at the next edge
  logic          stall_d = 1'b0;
  logic [WO-1:0] o_d = '0;
  logic [WT-1:0] t_d = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      stall_d <= 1'b0;
    end else begin
      check("ready_eq", WO'(o_ready), WO'(!o_valid || i_ready));
      if (stall_d) begin
        check("hold_valid", WO'(o_valid), 1);
        check("hold_o", oO, o_d);
        check("hold_tag", WO'(o_tag), WO'(t_d));
      end
      if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $error("FAIL spurious_out: observed o=%h tag=%h expected no output", oO, o_tag);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_prod", oO, e.o);
          check("sb_tag", WO'(o_tag), WO'(e.tag));
        end
      end
      if (i_valid && o_ready) sb.push_back({ref_mul(iX, iY, i_signed), i_tag});
      stall_d <= o_valid && !i_ready;
      o_d     <= oO;
      t_d     <= o_tag;
    end
  end

  task automatic single(input logic [WI-1:0] x, input logic [WI-1:0] y, input logic sg,
                        input logic [WT-1:0] tg, input logic [WO-1:0] exp, input string name);
    i_ready = 1'b1;
    @(posedge clk); #1;
    iX = x; iY = y; i_signed = sg; i_tag = tg; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 check({name, "_early"}, WO'(o_valid), 0);
    @(posedge clk); #1;
    check({name, "_valid"}, WO'(o_valid), 1);
    check(name, oO, exp);
    check({name, "_tag"}, WO'(o_tag), WO'(tg));
    @(posedge clk); #1;
    check({name, "_pulse"}, WO'(o_valid), 0);
  endtask

  task automatic stream(input int n, input bit rnd, input string name);
    bit all_ready = 1'b1;
    bit acc;
    int guard;
    for (int i = 0; i < n; i++) begin
      iX = WI'($urandom); iY = WI'($urandom);
      i_signed = 1'($urandom_range(0, 1));
      i_tag = WT'($urandom_range(0, 15));
      i_valid = 1'b1;
      guard = 0;
      do begin
        i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        acc = o_ready;
        if (!o_ready) all_ready = 1'b0;
        @(posedge clk); #1;
        guard++;
      end while (!acc && guard < 100);
      if (!acc) check({name, "_accept_timeout"}, WO'(guard), 0);
    end
    i_valid = 1'b0;
    guard = 0;
    while ((sb.size() != 0 || !o_idle) && guard < 300) begin
      i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      guard++;
    end
    i_ready = 1'b1;
    check({name, "_drained"}, WO'(sb.size()), 0);
    check({name, "_idle"}, WO'(o_idle), 1);
    if (!rnd) check({name, "_full_rate"}, WO'(all_ready), 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", WO'(o_valid), 0);
    check("rst_idle", WO'(o_idle), 1);
    check("rst_o", oO, 0);
    check("rst_tag", WO'(o_tag), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    single(16'hFFFF, 16'hFFFF, 1'b0, 4'h3, 32'hFFFE0001, "u_ffff_sq");
    single(16'h8000, 16'h8000, 1'b1, 4'h7, 32'h40000000, "s_min_sq");
    single(16'hFFFF, 16'h0001, 1'b1, 4'hA, 32'hFFFFFFFF, "s_m1_x1");
    single(16'hFFFF, 16'h0001, 1'b0, 4'hC, 32'h0000FFFF, "u_ffff_x1");

    stream(100, 1'b0, "stream_full");
    stream(100, 1'b1, "stream_bp");

    // reset with three transactions in flight
    i_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iX = 16'h1111 * WI'(i + 1); iY = 16'h0101; i_signed = 1'b0;
      i_tag = WT'(i + 1); i_valid = 1'b1;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", WO'(o_valid), 0);
    check("midrst_idle", WO'(o_idle), 1);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("midrst_no_late", WO'(o_valid), 0);
    end
    single(16'h1234, 16'h0010, 1'b0, 4'h5, 32'h00012340, "post_rst");

    single(16'h00FF, 16'h00FF, 1'b0, 4'h1, 32'h0000FE01, "leaf_ff_sq");
    single(16'hFF00, 16'hFF01, 1'b0, 4'h2, 32'hFE01FF00, "leaf_ff00_ff01");
    @(posedge clk); #1;
    check("final_idle", WO'(o_idle), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
